// File: rtl/pong_pkg.sv
// Shared game constants and the paddle bitmap helper used by the encoder,
// the game core and the renderer.
package pong_pkg;

  localparam int SCREEN_H       = 32;
  localparam int PADDLE_LEN_DEF = 4;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Rows pos .. pos+len-1 set; 7-bit compare so pos+len = 32 cannot overflow.
  function automatic logic [31:0] paddle_mask(input logic [5:0] pos, input logic [5:0] len);
    logic [31:0] m;
    logic [6:0]  top;
    top = {1'b0, pos} + {1'b0, len};
    for (int i = 0; i < SCREEN_H; i++) begin
      m[i] = (7'(i) >= {1'b0, pos}) && (7'(i) < top);
    end
    return m;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchroniser plus level debouncer for one encoder phase.
// A new level is accepted only after DEBOUNCE consecutive differing samples.
module quad_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int                CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      // debounce stage
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/paddle_encoder.sv
// Quadrature encoder to saturating paddle position and 32-bit paddle bitmap.
// Pipeline: debounced phases -> decode/accumulate -> position -> bitmap.
module paddle_encoder
  import pong_pkg::*;
#(
  parameter int HEIGHT       = SCREEN_H,
  parameter int PADDLE_LEN   = PADDLE_LEN_DEF,
  parameter int CENTER_POS   = 14,
  parameter int DEBOUNCE     = 3,
  parameter int STEPS_PER_PX = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        center,
  output logic [4:0]  position,
  output logic [31:0] paddle,
  output logic        step_err
);

  localparam int                       ACC_W   = $clog2(STEPS_PER_PX) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_PX - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [5:0]              MAX_POS = 6'(HEIGHT - PADDLE_LEN);
  localparam logic [5:0]              CTR_POS = 6'(CENTER_POS);
  localparam logic [5:0]              LEN6    = 6'(PADDLE_LEN);

  logic [1:0]              ab_p0;
  logic [1:0]              prev_ab;
  step_t                   step_p0;
  logic signed [ACC_W-1:0] acc_p1;
  logic                    up_p1;
  logic                    dn_p1;
  logic [5:0]              pos_p2;

  // Gray-code phase index along the forward direction 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_t decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = phase(cur) - phase(prev);
    case (d)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      default: return STEP_ERR;
    endcase
  endfunction

  function automatic logic [5:0] sat_move(input logic [5:0] pos, input logic up, input logic dn);
    if (up && (pos < MAX_POS)) return pos + 6'd1;
    if (dn && (pos != 6'd0))   return pos - 6'd1;
    return pos;
  endfunction

  quad_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (enc_a),
    .level   (ab_p0[1])
  );

  quad_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (enc_b),
    .level   (ab_p0[0])
  );

  assign step_p0 = decode(prev_ab, ab_p0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab  <= 2'b00;
      step_err <= 1'b0;
      acc_p1   <= '0;
      up_p1    <= 1'b0;
      dn_p1    <= 1'b0;
      pos_p2   <= CTR_POS;
      paddle   <= paddle_mask(CTR_POS, LEN6);
    end else begin
      // decode / accumulate stage
      prev_ab  <= ab_p0;
      step_err <= (step_p0 == STEP_ERR);
      up_p1    <= 1'b0;
      dn_p1    <= 1'b0;
      if (center) begin
        acc_p1 <= '0;
      end else if (step_p0 == STEP_FWD) begin
        if (acc_p1 == ACC_MAX) begin
          acc_p1 <= '0;
          up_p1  <= 1'b1;
        end else begin
          acc_p1 <= acc_p1 + ACC_ONE;
        end
      end else if (step_p0 == STEP_REV) begin
        if (acc_p1 == ACC_MIN) begin
          acc_p1 <= '0;
          dn_p1  <= 1'b1;
        end else begin
          acc_p1 <= acc_p1 - ACC_ONE;
        end
      end
      // position stage
      pos_p2 <= center ? CTR_POS : sat_move(pos_p2, up_p1, dn_p1);
      // bitmap stage
      paddle <= paddle_mask(pos_p2, LEN6);
    end
  end

  assign position = pos_p2[4:0];

endmodule

// File: tb/tb_paddle_encoder.sv
// Directed and randomized bench for paddle_encoder against a window-based
// behavioural model of debounce, quadrature stepping and saturation.
module tb_paddle_encoder;

  localparam int CENTER = 14;
  localparam int LEN    = 4;
  localparam int D      = 3;
  localparam int STEPS  = 2;
  localparam int MAXP   = 32 - LEN;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        center = 1'b0;
  logic [4:0]  position;
  logic [31:0] paddle;
  logic        step_err;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;

  paddle_encoder #(
    .HEIGHT(32), .PADDLE_LEN(LEN), .CENTER_POS(CENTER), .DEBOUNCE(D), .STEPS_PER_PX(STEPS)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .center   (center),
    .position (position),
    .paddle   (paddle),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_ha, m_hb;
  logic [1:0]  m_lvl, m_prev;
  int          m_acc, m_move, m_pos;
  logic [31:0] m_paddle;
  logic        m_err;

  function automatic logic [31:0] ref_mask(input int pos);
    logic [63:0] w;
    w = ((64'd1 << LEN) - 64'd1) << pos;
    return w[31:0];
  endfunction

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Level flips once the last D synchronised samples all disagree with it.
  function automatic logic flips(input logic [15:0] h, input logic lvl);
    for (int j = 1; j <= D; j++) begin
      if (h[j] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int mv, nacc, np;
    if (!reset_n) begin
      m_ha <= '0; m_hb <= '0; m_lvl <= 2'b00; m_prev <= 2'b00;
      m_acc <= 0; m_move <= 0; m_pos <= CENTER;
      m_paddle <= ref_mask(CENTER); m_err <= 1'b0;
    end else begin
      mv = 0;
      nacc = m_acc;
      if (m_lvl != m_prev && m_lvl == fwd_next(m_prev)) begin
        if (m_acc == STEPS - 1) begin mv = 1; nacc = 0; end else nacc = m_acc + 1;
      end else if (m_lvl != m_prev && m_lvl == rev_next(m_prev)) begin
        if (m_acc == -(STEPS - 1)) begin mv = -1; nacc = 0; end else nacc = m_acc - 1;
      end
      if (center) begin nacc = 0; mv = 0; end
      np = m_pos + m_move;
      if (np < 0) np = 0;
      if (np > MAXP) np = MAXP;
      if (center) np = CENTER;
      m_err    <= (m_lvl == ~m_prev);
      m_prev   <= m_lvl;
      m_acc    <= nacc;
      m_move   <= mv;
      m_pos    <= np;
      m_paddle <= ref_mask(m_pos);
      m_lvl    <= {m_lvl[1] ^ flips(m_ha, m_lvl[1]), m_lvl[0] ^ flips(m_hb, m_lvl[0])};
      m_ha     <= {m_ha[14:0], enc_a};
      m_hb     <= {m_hb[14:0], enc_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pos"}, 32'(position), 32'(m_pos));
    chk({tag, ".pad"}, paddle, m_paddle);
    chk({tag, ".err"}, 32'(step_err), 32'(m_err));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_model(tag);
      if (step_err === 1'b1) err_seen++;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab, input int hold, input string tag);
    enc_a = ab[1];
    enc_b = ab[0];
    run(hold, tag);
  endtask

  initial begin
    logic [1:0] cur;
    logic [1:0] nxt;
    int hold;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.pos", 32'(position), 32'd14);
    chk("rst.pad", paddle, 32'h0003C000);
    chk("rst.err", 32'(step_err), 32'd0);
    reset_n = 1'b1;
    run(3, "idle");
    chk("idle.pos", 32'(position), 32'd14);

    // Four forward steps, checking the move latency on the second.
    set_ab(2'b10, 10, "fwd1");
    enc_a = 1'b1; enc_b = 1'b1;
    run(6, "fwd2a");
    chk("lat6.pos", 32'(position), 32'd14);
    run(1, "fwd2b");
    chk("lat7.pos", 32'(position), 32'd15);
    run(1, "fwd2c");
    chk("lat8.pad", paddle, 32'h00078000);
    run(2, "fwd2d");
    set_ab(2'b01, 10, "fwd3");
    set_ab(2'b00, 10, "fwd4");
    chk("fwd4.pos", 32'(position), 32'd16);

    cur = 2'b00;
    for (int i = 0; i < 60; i++) begin
      cur = rev_next(cur);
      set_ab(cur, 6, "rev");
    end
    run(10, "revs");
    chk("sat0.pos", 32'(position), 32'd0);
    chk("sat0.pad", paddle, 32'h0000000F);
    for (int i = 0; i < 60; i++) begin
      cur = fwd_next(cur);
      set_ab(cur, 6, "fwd");
    end
    run(10, "fwds");
    chk("sat28.pos", 32'(position), 32'd28);
    chk("sat28.pad", paddle, 32'hF0000000);

    // Glitches shorter than the debounce window.
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      enc_a = 1'b1;
      run(2, "glitch");
      enc_a = 1'b0;
      run(8, "glitch");
    end
    chk("glitch.pos", 32'(position), 32'd28);
    chk("glitch.err", 32'(err_seen), 32'd0);

    // Both phases flipping together.
    err_seen = 0;
    set_ab(2'b11, 10, "both1");
    chk("both1.errcnt", 32'(err_seen), 32'd1);
    chk("both1.pos", 32'(position), 32'd28);
    set_ab(2'b00, 10, "both2");
    chk("both2.errcnt", 32'(err_seen), 32'd2);

    // Recentre on the very cycle a move commits.
    set_ab(2'b10, 10, "ctr1");
    enc_a = 1'b1; enc_b = 1'b1;
    run(6, "ctr2");
    center = 1'b1;
    run(1, "ctr3");
    center = 1'b0;
    chk("ctr.pos", 32'(position), 32'd14);
    run(3, "ctr4");
    chk("ctr.pad", paddle, 32'h0003C000);
    set_ab(2'b01, 10, "ctr5");
    chk("ctr.nomove", 32'(position), 32'd14);
    set_ab(2'b00, 10, "ctr6");
    chk("ctr.move", 32'(position), 32'd15);

    // Randomized rotation with occasional recentre.
    cur = 2'b00;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0:       nxt = 2'($urandom_range(0, 3));
        1, 2, 3: nxt = rev_next(cur);
        default: nxt = fwd_next(cur);
      endcase
      cur = nxt;
      hold = $urandom_range(1, 8);
      enc_a = cur[1];
      enc_b = cur[0];
      if ($urandom_range(0, 15) == 0) begin
        center = 1'b1;
        run(1, "rnd");
        center = 1'b0;
        run(hold - 1, "rnd");
      end else begin
        run(hold, "rnd");
      end
    end

    // Asynchronous reset between edges, then a double-bit change out of reset.
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst.pos", 32'(position), 32'd14);
    chk("arst.pad", paddle, 32'h0003C000);
    chk("arst.err", 32'(step_err), 32'd0);
    enc_a = 1'b1;
    enc_b = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    err_seen = 0;
    run(12, "post");
    chk("post.errcnt", 32'(err_seen), 32'd1);
    chk("post.pos", 32'(position), 32'd14);

    cur = 2'b11;
    for (int i = 0; i < 100; i++) begin
      cur = ($urandom_range(0, 1) == 0) ? fwd_next(cur) : rev_next(cur);
      set_ab(cur, $urandom_range(2, 7), "rnd2");
    end
    run(10, "end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
